opl_reg_writer: RTL

OPL_REG_WRITER -- requirements
Module: opl_reg_writer

---
 rtl/opl3_pkg.sv | 35 +++
 rtl/opl_reg_writer_if.sv | 19 +
 rtl/opl_reg_writer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/opl3_pkg.sv
// opl3_pkg
//   Shared constants and types for the OPL register writer: register image
//   size, bank-1 offset, status-byte bit positions, the addresses of the
//   registers that get special handling, and the writer FSM state type.
package opl3_pkg;

   localparam int OPL_REG_COUNT = 512;
   localparam int BANK2_OFFSET  = 256;

   localparam int STAT_IRQ_BIT = 7;
   localparam int STAT_FT1_BIT = 6;
   localparam int STAT_FT2_BIT = 5;

   // Timer control register (bit 7 is a self-clearing IRQ reset strobe)
   localparam logic [8:0] ADDR_TIMER_CTRL = 9'h004;
   // OPL3 enable register; bit 0 gates every other bank-1 data write
   localparam logic [8:0] ADDR_OPL3_EN    = 9'(BANK2_OFFSET + 5);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ADDR_BUSY = 2'd1,
      DATA_BUSY = 2'd2
   } opl_state_e;

   function automatic logic [7:0] status_byte(input logic irq, input logic ft1,
                                              input logic ft2);
      logic [7:0] s;
      s               = 8'h00;
      s[STAT_IRQ_BIT] = irq;
      s[STAT_FT1_BIT] = ft1;
      s[STAT_FT2_BIT] = ft2;
      return s;
   endfunction

endpackage

// File: rtl/opl_reg_writer_if.sv
// opl_reg_writer_if
//   Host I/O bus of the OPL register writer.
//   io_wr   : one-cycle write strobe
//   io_rd   : one-cycle read strobe
//   io_addr : port select (0/2 = bank address, 1/3 = data)
//   io_din  : write data
//   io_dout : read data, valid the cycle after io_rd and held until the next read
interface opl_reg_writer_if;
   logic       io_wr;
   logic       io_rd;
   logic [1:0] io_addr;
   logic [7:0] io_din;
   logic [7:0] io_dout;

   modport master (output io_wr, output io_rd, output io_addr, output io_din,
                   input io_dout);
   modport slave  (input io_wr, input io_rd, input io_addr, input io_din,
                   output io_dout);
endinterface

// File: rtl/opl_reg_writer.sv
// opl_reg_writer
//   Accepts OPL-style address/data port writes from a host and keeps the
//   512-entry register image. After each accepted write a busy window of
//   ADDR_WAIT or DATA_WAIT cycles is held open; writes arriving inside the
//   window are dropped and flagged on wr_drop.
// Ports
//   clk           : clock, rising edge
//   reset         : synchronous, active-high
//   sample_clk_en : sample-rate enable; clears the timer-control IRQ reset bit
//   bus           : host I/O bus (slave side)
//   irq, ft1, ft2 : timer status flags returned on a port-0 read
//   opl_reg       : register image, indexed bank*256 + index
//   busy          : high while a write window is open
//   wr_drop       : one-cycle pulse after a write discarded for being busy
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | no window open, next write is accepted
// ADDR_BUSY | counting down the address-write window
// DATA_BUSY | counting down the data-write window
module opl_reg_writer
   import opl3_pkg::*;
#(
   parameter int ADDR_WAIT = 32,
   parameter int DATA_WAIT = 84
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_clk_en,
   opl_reg_writer_if.slave     bus,
   input  logic                irq,
   input  logic                ft1,
   input  logic                ft2,
   output logic [7:0]          opl_reg [OPL_REG_COUNT],
   output logic                busy,
   output logic                wr_drop
);

   localparam int WAIT_MAX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
   localparam int CNT_W    = $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] ADDR_LOAD = CNT_W'(ADDR_WAIT - 1);
   localparam logic [CNT_W-1:0] DATA_LOAD = CNT_W'(DATA_WAIT - 1);

   opl_state_e       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [8:0]       r_addr, w_addr_nxt;
   logic             r_wr_drop, w_drop_nxt;
   logic [7:0]       r_dout;
   logic             w_data_wr;
   logic             w_bank1_lock;
   logic             w_reg_we;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_addr    <= '0;
         r_wr_drop <= 1'b0;
         r_dout    <= 8'h00;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_addr    <= w_addr_nxt;
         r_wr_drop <= w_drop_nxt;
         if (bus.io_rd)
            r_dout <= (bus.io_addr == 2'd0) ? status_byte(irq, ft1, ft2) : 8'hFF;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_addr_nxt  = r_addr;
      w_data_wr   = 1'b0;
      w_drop_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.io_wr) begin
               if (!bus.io_addr[0]) begin
                  w_addr_nxt  = {bus.io_addr[1], bus.io_din};
                  w_cnt_nxt   = ADDR_LOAD;
                  w_state_nxt = ADDR_BUSY;
               end else begin
                  w_data_wr   = 1'b1;
                  w_cnt_nxt   = DATA_LOAD;
                  w_state_nxt = DATA_BUSY;
               end
            end
         end
         ADDR_BUSY, DATA_BUSY: begin
            w_drop_nxt = bus.io_wr;
            if (r_cnt == '0)
               w_state_nxt = IDLE;
            else
               w_cnt_nxt = r_cnt - CNT_W'(1);
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Bank-1 data writes are silently ignored until OPL3 mode is enabled,
   // except the enable register itself. The busy window still opens.
   assign w_bank1_lock = r_addr[8] && !opl_reg[ADDR_OPL3_EN][0]
                         && (r_addr != ADDR_OPL3_EN);
   assign w_reg_we     = w_data_wr && !w_bank1_lock;

   // The self-clear is scheduled first so a same-edge write overrides it.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < OPL_REG_COUNT; i++)
            opl_reg[i] <= 8'h00;
      end else begin
         if (sample_clk_en)
            opl_reg[ADDR_TIMER_CTRL][7] <= 1'b0;
         if (w_reg_we) begin
            if ((r_addr == ADDR_TIMER_CTRL) && bus.io_din[7])
               opl_reg[ADDR_TIMER_CTRL][7] <= 1'b1;
            else
               opl_reg[r_addr] <= bus.io_din;
         end
      end
   end

   assign busy        = (r_state != IDLE);
   assign wr_drop     = r_wr_drop;
   assign bus.io_dout = r_dout;

endmodule
